// File: rtl/apb_ctrl_pkg.sv
// rtl/apb_ctrl_pkg.sv - shared state encoding and default sizing for the APB arbitrating master
//
// Purpose: FSM state enum and default parameter values used by apb_arb_master
//          and its sub-modules.
package apb_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_TIMEOUT = 15;

endpackage

// File: rtl/apb_rr_arbiter.sv
// rtl/apb_rr_arbiter.sv - two-way round-robin grant logic
//
// Purpose: picks one of two requesters; on contention the requester not
//          granted last wins. History updates only when the grant is used.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   req[1:0]    request vector
//   advance     grant is being consumed this cycle; record who got it
//   grant[1:0]  one-hot grant, or zero when nothing is requested
module apb_rr_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // Index of the requester granted most recently. Resets to 1 so that
  // requester 0 wins the first contention.
  logic last_q;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (advance && (grant != 2'b00)) begin
      last_q <= grant[1];
    end
  end

endmodule

// File: rtl/apb_arb_master.sv
// rtl/apb_arb_master.sv - APB master shared by two requesters with round-robin arbitration
//
// Purpose: accepts transfer requests from two requesters, runs each one as an
//          APB SETUP/ACCESS sequence with a bounded wait, and returns the
//          result to the owning requester as a one-cycle response pulse.
// Ports:
//   pclk, presetn                    clock, asynchronous active-low reset
//   req_valid/req_write [1:0]        per-requester request and direction
//   req_addr  [2*ADDR_W-1:0]         per-requester address (slice i)
//   req_wdata [2*DATA_W-1:0]         per-requester write data (slice i)
//   req_ready [1:0]                  accept pulse (combinational)
//   rsp_valid [1:0], rsp_rdata, rsp_err   completion pulse and result
//   psel, penable, pwrite, paddr, pwdata  APB master outputs
//   prdata, pready, pslverr               APB slave response
module apb_arb_master
  import apb_ctrl_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                pclk,
  input  logic                presetn,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          req_ready,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   paddr,
  output logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pready,
  input  logic                pslverr
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  apb_state_e       state_q, state_d;
  logic [CNT_W-1:0] wait_q;
  logic             owner_q;
  logic [1:0]       grant;
  logic             done;
  logic             timeout_hit;
  logic             can_start;
  logic             accept;

  apb_rr_arbiter u_arb (
    .clk     (pclk),
    .rst_n   (presetn),
    .req     (req_valid),
    .advance (accept),
    .grant   (grant)
  );

  always_comb begin
    state_d     = state_q;
    done        = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid != 2'b00) state_d = SETUP;
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          done = 1'b1;
        end else if (wait_q == CNT_W'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th cycle with pready low: give up now.
          done        = 1'b1;
          timeout_hit = 1'b1;
        end
        if (done) state_d = (req_valid != 2'b00) ? SETUP : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A new transfer can be taken from IDLE or from the completing ACCESS
  // cycle, which gives back-to-back transfers without an IDLE gap.
  assign can_start = (state_q == IDLE) || done;
  assign accept    = can_start && (req_valid != 2'b00);
  assign req_ready = (presetn && can_start) ? grant : 2'b00;

  assign psel    = (state_q != IDLE);
  assign penable = (state_q == ACCESS);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      owner_q   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 2'b00;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rsp_valid <= 2'b00;

      if (state_q == SETUP) begin
        wait_q <= '0;
      end else if (state_q == ACCESS && !pready && wait_q != CNT_W'(TIMEOUT)) begin
        wait_q <= wait_q + 1'b1;
      end

      // Response uses the pwrite of the finishing transfer; a same-edge
      // accept only replaces it for the next one.
      if (done) begin
        rsp_valid <= owner_q ? 2'b10 : 2'b01;
        rsp_err   <= timeout_hit ? 1'b1 : pslverr;
        rsp_rdata <= (timeout_hit || pwrite) ? '0 : prdata;
      end

      if (accept) begin
        owner_q <= grant[1];
        pwrite  <= grant[1] ? req_write[1] : req_write[0];
        paddr   <= grant[1] ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
        pwdata  <= grant[1] ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_apb_arb_master.sv
// tb/tb_apb_arb_master.sv - directed self-checking bench for apb_arb_master
module tb_apb_arb_master;

  logic        pclk = 1'b0;
  logic        presetn;
  logic [1:0]  req_valid, req_write;
  logic [15:0] req_addr, req_wdata;
  logic [1:0]  req_ready, rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr, pwdata;
  logic [7:0]  prdata;
  logic        pready, pslverr;

  int n_pass  = 0;
  int n_total = 0;

  apb_arb_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(15)) dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge pclk);
  endtask

  initial begin
    int n;
    presetn   = 1'b0;
    req_valid = 2'b11;
    req_write = 2'b11;
    req_addr  = 16'hFFFF;
    req_wdata = 16'hFFFF;
    prdata    = 8'h00;
    pready    = 1'b1;
    pslverr   = 1'b0;

    // Reset state, with requests pending to show req_ready stays low
    repeat (2) tick();
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_pwrite", pwrite, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    presetn   = 1'b1;
    req_valid = 2'b00;
    tick();

    // Single zero-wait write from requester 0
    req_valid = 2'b01; req_write = 2'b01; req_addr = 16'h0005; req_wdata = 16'h00A5; pready = 1'b1;
    #1 check("wr_ready", req_ready, 2'b01);
    tick(); req_valid = 2'b00;
    check("wr_setup_psel", psel, 1);
    check("wr_setup_penable", penable, 0);
    check("wr_paddr", paddr, 8'h05);
    check("wr_pwdata", pwdata, 8'hA5);
    check("wr_pwrite", pwrite, 1);
    tick();
    check("wr_access_penable", penable, 1);
    check("wr_no_early_rsp", rsp_valid, 0);
    tick();
    check("wr_idle_psel", psel, 0);
    check("wr_rsp_valid", rsp_valid, 2'b01);
    check("wr_rsp_err", rsp_err, 0);
    check("wr_rsp_rdata", rsp_rdata, 0);
    check("wr_paddr_hold", paddr, 8'h05);
    tick();
    check("wr_rsp_pulse", rsp_valid, 0);

    // Read from requester 1 with three wait cycles
    req_valid = 2'b10; req_write = 2'b00; req_addr = 16'h0300; pready = 1'b0; prdata = 8'h77;
    #1 check("rd_ready", req_ready, 2'b10);
    tick(); req_valid = 2'b00;
    check("rd_paddr", paddr, 8'h03);
    check("rd_pwrite", pwrite, 0);
    repeat (3) tick();
    check("rd_wait_hold", penable, 1);
    check("rd_wait_no_rsp", rsp_valid, 0);
    tick(); pready = 1'b1; prdata = 8'h3C;
    tick();
    check("rd_rsp_valid", rsp_valid, 2'b10);
    check("rd_rsp_rdata", rsp_rdata, 8'h3C);
    check("rd_rsp_err", rsp_err, 0);
    check("rd_idle", psel, 0);

    // Contention from reset: order 0,1,0,1 back-to-back
    presetn = 1'b0; tick(); presetn = 1'b1;
    req_valid = 2'b11; req_write = 2'b11; req_addr = 16'h2110; req_wdata = 16'hB1B0; pready = 1'b1;
    #1 check("ct_ready0", req_ready, 2'b01);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("ct_setup_psel%0d", k), psel, 1);
      check($sformatf("ct_setup_penable%0d", k), penable, 0);
      check($sformatf("ct_paddr%0d", k), paddr, (k % 2) ? 8'h21 : 8'h10);
      if (k > 0) check($sformatf("ct_rsp%0d", k - 1), rsp_valid, ((k - 1) % 2) ? 2'b10 : 2'b01);
      tick();
      check($sformatf("ct_access%0d", k), penable, 1);
      if (k < 3) begin
        check($sformatf("ct_ready%0d", k + 1), req_ready, ((k + 1) % 2) ? 2'b10 : 2'b01);
      end else begin
        req_valid = 2'b00;
        #1 check("ct_ready_none", req_ready, 0);
      end
    end
    tick();
    check("ct_end_idle", psel, 0);
    check("ct_rsp3", rsp_valid, 2'b10);

    // Timeout: pready never rises
    req_valid = 2'b01; req_write = 2'b00; req_addr = 16'h000A; pready = 1'b0; prdata = 8'hFF;
    #1 check("to_ready", req_ready, 2'b01);
    tick(); req_valid = 2'b00;
    tick();
    n = 0;
    while (penable === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    check("to_access_cycles", n, 15);
    check("to_idle", psel, 0);
    check("to_rsp_valid", rsp_valid, 2'b01);
    check("to_rsp_err", rsp_err, 1);
    check("to_rsp_rdata", rsp_rdata, 0);
    pready = 1'b1;

    // Slave error on a write from requester 1
    req_valid = 2'b10; req_write = 2'b10; req_addr = 16'h0700; pslverr = 1'b1; prdata = 8'h55;
    #1 check("se_ready", req_ready, 2'b10);
    tick(); req_valid = 2'b00;
    tick();
    tick();
    check("se_rsp_valid", rsp_valid, 2'b10);
    check("se_rsp_err", rsp_err, 1);
    check("se_rsp_rdata", rsp_rdata, 0);
    pslverr = 1'b0;

    // Reset mid-ACCESS after requester 0 was granted last
    req_valid = 2'b01; req_write = 2'b00; req_addr = 16'h0009; pready = 1'b0;
    #1 check("rm_ready", req_ready, 2'b01);
    tick(); req_valid = 2'b00;
    tick();
    check("rm_in_access", penable, 1);
    presetn = 1'b0;
    #1 check("rm_psel_drop", psel, 0);
    check("rm_penable_drop", penable, 0);
    tick();
    check("rm_no_rsp_a", rsp_valid, 0);
    tick();
    presetn = 1'b1; pready = 1'b1; req_valid = 2'b11;
    #1 check("rm_first_win", req_ready, 2'b01);
    check("rm_no_rsp_b", rsp_valid, 0);
    tick(); req_valid = 2'b00;
    check("rm_no_rsp_c", rsp_valid, 0);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/apb_arb_master.md
APB_ARB_MASTER -- requirements
Module: apb_arb_master

Interface
REQ-001 Parameter ADDR_W, default 8, sets the APB/request address width.
REQ-002 Parameter DATA_W, default 8, sets the APB/request data width.
REQ-003 Parameter TIMEOUT, default 15, sets the maximum ACCESS cycles with pready low before forced termination.
REQ-004 pclk  in  1  the single clock; all logic on its rising edge.
REQ-005 presetn  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  2  per-requester transfer request; held high until accepted.
REQ-007 req_write  in  2  per-requester direction, 1=write, 0=read.
REQ-008 req_addr  in  2*ADDR_W  per-requester address; requester i uses slice i.
REQ-009 req_wdata  in  2*DATA_W  per-requester write data; requester i uses slice i.
REQ-010 req_ready  out  2  one-cycle accept pulse for requester i.
REQ-011 rsp_valid  out  2  one-cycle completion pulse for requester i.
REQ-012 rsp_rdata  out  DATA_W  read data for the completing transfer; valid with rsp_valid.
REQ-013 rsp_err  out  1  error flag (pslverr or timeout); valid with rsp_valid.
REQ-014 psel, penable, pwrite  out  1 each  APB master control.
REQ-015 paddr  out  ADDR_W  and  pwdata  out  DATA_W  APB master address and write data.
REQ-016 prdata  in  DATA_W,  pready  in  1,  pslverr  in  1  APB slave response.

Function
REQ-017 The FSM SHALL have states IDLE (psel=0, penable=0), SETUP (psel=1, penable=0) and ACCESS (psel=1, penable=1).
REQ-018 IDLE->SETUP SHALL occur on the edge where any req_valid is high.
REQ-019 SETUP->ACCESS SHALL occur unconditionally after exactly one cycle.
REQ-020 ACCESS SHALL hold while pready=0 and the wait counter is below TIMEOUT.
REQ-021 ACCESS SHALL complete on pready=1, or on the cycle the wait counter reaches TIMEOUT.
REQ-022 On completion, the FSM SHALL go to SETUP if any req_valid is high, else to IDLE.
REQ-023 ACCESS->SETUP back-to-back SHALL be supported with no IDLE cycle between transfers.
REQ-024 req_ready[i] SHALL be high combinationally in the cycle before the edge that enters SETUP for requester i.
REQ-025 req_ready SHALL have at most one bit set in any cycle.
REQ-026 On acceptance, the granted requester's write, addr and wdata SHALL be latched into pwrite, paddr and pwdata.
REQ-027 pwrite, paddr and pwdata SHALL be stable from SETUP through ACCESS completion, and SHALL hold their value in IDLE.
REQ-028 Arbitration SHALL be 2-way round-robin.
REQ-029 When both requesters are valid, the grant SHALL go to the requester not granted last.
REQ-030 When only one requester is valid, that requester SHALL be granted regardless of history.
REQ-031 rsp_valid[i] SHALL pulse in the cycle after the completing ACCESS edge, for the requester owning the transfer.
REQ-032 On pready completion, rsp_rdata SHALL be the prdata sampled at that edge for reads, and 0 for writes.
REQ-033 On pready completion, rsp_err SHALL equal the pslverr sampled at that edge.
REQ-034 On timeout completion, rsp_err SHALL be 1 and rsp_rdata SHALL be 0.
REQ-035 The wait counter SHALL be ceil(log2(TIMEOUT+1)) bits, clear on entry to ACCESS, increment each ACCESS cycle with pready=0, and saturate.
REQ-036 pready=1 on the first ACCESS cycle SHALL give a zero-wait transfer of 2 APB cycles total.
REQ-037 A req_valid deasserted before acceptance SHALL NOT be granted and SHALL produce no response.

Reset
REQ-038 While presetn=0, the block SHALL hold: state IDLE; psel, penable, pwrite = 0; paddr, pwdata = 0; req_ready, rsp_valid = 0; rsp_rdata, rsp_err = 0; wait counter 0.
REQ-039 While presetn=0, last-grant SHALL be 1, so that requester 0 wins the first contention.
REQ-040 Assertion of presetn SHALL take effect immediately, without a clock edge.
REQ-041 A reset during SETUP or ACCESS SHALL drop psel and penable at once, and the interrupted transfer SHALL never produce a response.

Structure
REQ-042 Package apb_ctrl_pkg SHALL hold the state enum (IDLE=0, SETUP=1, ACCESS=2) and the default width/TIMEOUT constants.
REQ-043 The round-robin grant logic SHALL be sub-module apb_rr_arbiter, with inputs req[1:0] and advance, and output grant[1:0], one-hot or zero.

Verification
REQ-044 Single write: req0 write addr=0x05 wdata=0xA5, pready=1 -> SETUP then ACCESS (one cycle each), paddr=0x05, pwdata=0xA5, rsp_valid[0] pulse, rsp_err=0.
REQ-045 Read with waits: req1 read addr=0x03, pready low 3 ACCESS cycles, prdata=0x3C on the 4th -> rsp_rdata=0x3C, rsp_valid[1] 1 cycle after completion.
REQ-046 Contention: both requesters valid from reset, held for 4 transfers -> grant order 0,1,0,1 with back-to-back SETUP and no IDLE between transfers.
REQ-047 Timeout: pready held 0 -> ACCESS ends after 15 cycles, rsp_err=1, rsp_rdata=0x00, then IDLE.
REQ-048 Slave error: pslverr=1 with pready=1 on a write -> rsp_err=1.
REQ-049 Reset mid-ACCESS: presetn low during ACCESS -> psel and penable 0 in the same cycle, no rsp_valid, and requester 0 wins the next contention.
